csirx_packet_handler: RTL and testbench

- Sits directly downstream of the two-lane word aligner.
- Consumes aligned 16-bit words, lane 0 byte in bits [15:8], and parses the CSI-2 packet header (DI, WC, ECC).
- Decodes short packets into frame/line sync pulses.
- Passes long-packet payload to the pixel unpacker with byte enables and a last flag; strips the CRC trailer.

---
 rtl/csirx_packet_handler.sv | 205 ++++++++++++++++++++
 tb/tb_csirx_packet_handler.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csirx_packet_handler.sv
// CSI-2 packet handler: parses the DI/WC/ECC header from aligned two-lane words, emits sync
// pulses for short packets and forwards long-packet payload with byte enables, dropping the CRC.
module csirx_packet_handler #(
  parameter logic [1:0] VC_SELECT = 2'd0,
  parameter bit         VC_FILTER = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] word_in,
  input  logic        word_valid,
  output logic        frame_start,
  output logic        frame_end,
  output logic        line_start,
  output logic        line_end,
  output logic [15:0] frame_num,
  output logic [5:0]  data_type,
  output logic [1:0]  virtual_channel,
  output logic [15:0] payload,
  output logic        payload_valid,
  output logic [1:0]  payload_be,
  output logic        payload_last,
  output logic        hdr_ecc_err,
  output logic        pkt_truncated
);

  typedef enum logic [1:0] {StHdr0, StHdr1, StPayload, StDrain} state_e;

  // CSI-2 Hamming parity over {WC[15:8], WC[7:0], DI}; each mask selects the bits feeding P0..P5.
  function automatic logic [5:0] calc_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = ^(d & 24'hF12CB7);
    p[1] = ^(d & 24'hF2555B);
    p[2] = ^(d & 24'h749A6D);
    p[3] = ^(d & 24'hB8E38E);
    p[4] = ^(d & 24'hDF03F0);
    p[5] = ^(d & 24'hEFFC00);
    return p;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  di_q, di_d;
  logic [7:0]  wc_lo_q, wc_lo_d;
  logic [15:0] rem_q, rem_d;
  logic        fs_q, fs_d, fe_q, fe_d, ls_q, ls_d, le_q, le_d;
  logic        err_q, err_d, trunc_q, trunc_d;
  logic [15:0] fnum_q, fnum_d;
  logic [5:0]  dt_q, dt_d;
  logic [1:0]  vc_q, vc_d;
  logic [15:0] pay_q, pay_d;
  logic        pv_q, pv_d, last_q, last_d;
  logic [1:0]  be_q, be_d;

  logic [15:0] hdr_wc;
  logic [5:0]  hdr_dt;
  logic [1:0]  hdr_vc;
  logic        ecc_ok, vc_ok, is_short;

  assign hdr_wc   = {word_in[15:8], wc_lo_q};
  assign hdr_dt   = di_q[5:0];
  assign hdr_vc   = di_q[7:6];
  assign ecc_ok   = (word_in[7:0] == {2'b00, calc_ecc({hdr_wc, di_q})});
  assign vc_ok    = !VC_FILTER || (hdr_vc == VC_SELECT);
  assign is_short = (hdr_dt <= 6'h0F);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StHdr0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!word_valid) begin
      state_d = StHdr0;
    end else begin
      unique case (state_q)
        StHdr0:    state_d = StHdr1;
        StHdr1: begin
          if (!ecc_ok || !vc_ok || is_short || (hdr_wc == 16'd0)) state_d = StDrain;
          else                                                     state_d = StPayload;
        end
        StPayload: if (rem_q <= 16'd2) state_d = StDrain;
        StDrain:   state_d = StDrain;
      endcase
    end
  end

  always_comb begin
    di_d    = di_q;
    wc_lo_d = wc_lo_q;
    rem_d   = rem_q;
    fs_d    = 1'b0;
    fe_d    = 1'b0;
    ls_d    = 1'b0;
    le_d    = 1'b0;
    err_d   = 1'b0;
    trunc_d = 1'b0;
    fnum_d  = fnum_q;
    dt_d    = dt_q;
    vc_d    = vc_q;
    pay_d   = pay_q;
    pv_d    = 1'b0;
    be_d    = 2'b00;
    last_d  = 1'b0;
    if (!word_valid) begin
      // Burst ended while header or payload was still owed.
      if (state_q == StHdr1 || (state_q == StPayload && rem_q != 16'd0)) trunc_d = 1'b1;
    end else begin
      unique case (state_q)
        StHdr0: begin
          di_d    = word_in[15:8];
          wc_lo_d = word_in[7:0];
        end
        StHdr1: begin
          if (!ecc_ok) begin
            err_d = 1'b1;
          end else if (vc_ok) begin
            vc_d = hdr_vc;
            if (is_short) begin
              case (hdr_dt)
                6'h00: begin fs_d = 1'b1; fnum_d = hdr_wc; end
                6'h01: begin fe_d = 1'b1; fnum_d = hdr_wc; end
                6'h02: ls_d = 1'b1;
                6'h03: le_d = 1'b1;
                default: ;
              endcase
            end else begin
              dt_d  = hdr_dt;
              rem_d = hdr_wc;
            end
          end
        end
        StPayload: begin
          pay_d  = word_in;
          pv_d   = 1'b1;
          last_d = (rem_q <= 16'd2);
          if (rem_q >= 16'd2) begin
            be_d  = 2'b11;
            rem_d = rem_q - 16'd2;
          end else begin
            // Low byte of an odd-length tail is the first CRC byte.
            be_d  = 2'b10;
            rem_d = 16'd0;
          end
        end
        StDrain: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      di_q    <= '0;
      wc_lo_q <= '0;
      rem_q   <= '0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
      ls_q    <= 1'b0;
      le_q    <= 1'b0;
      err_q   <= 1'b0;
      trunc_q <= 1'b0;
      fnum_q  <= '0;
      dt_q    <= '0;
      vc_q    <= '0;
      pay_q   <= '0;
      pv_q    <= 1'b0;
      be_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      di_q    <= di_d;
      wc_lo_q <= wc_lo_d;
      rem_q   <= rem_d;
      fs_q    <= fs_d;
      fe_q    <= fe_d;
      ls_q    <= ls_d;
      le_q    <= le_d;
      err_q   <= err_d;
      trunc_q <= trunc_d;
      fnum_q  <= fnum_d;
      dt_q    <= dt_d;
      vc_q    <= vc_d;
      pay_q   <= pay_d;
      pv_q    <= pv_d;
      be_q    <= be_d;
      last_q  <= last_d;
    end
  end

  assign frame_start     = fs_q;
  assign frame_end       = fe_q;
  assign line_start      = ls_q;
  assign line_end        = le_q;
  assign frame_num       = fnum_q;
  assign data_type       = dt_q;
  assign virtual_channel = vc_q;
  assign payload         = pay_q;
  assign payload_valid   = pv_q;
  assign payload_be      = be_q;
  assign payload_last    = last_q;
  assign hdr_ecc_err     = err_q;
  assign pkt_truncated   = trunc_q;

endmodule

// File: tb/tb_csirx_packet_handler.sv
// Scoreboard bench for csirx_packet_handler: one unfiltered instance and one filtering VC1,
// both fed the same bursts and checked against a packet-level reference model.
module tb_csirx_packet_handler;

  // Hamming column code of each header bit d0..d23.
  localparam logic [5:0] ECC_COL [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19, 6'h1A, 6'h1C, 6'h23, 6'h25,
    6'h26, 6'h29, 6'h2A, 6'h2C, 6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

  // kind: 0 fs, 1 fe, 2 ls, 3 le, 4 ecc err, 5 truncated, 6 payload
  typedef struct {
    int          kind;
    logic [15:0] data;
    logic [1:0]  be;
    logic        last;
    logic [5:0]  dt;
    logic [1:0]  vc;
    longint      cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] word_in = 16'h0;
  logic        word_valid = 1'b0;
  longint      cyc = 0;
  int          total = 0;
  int          bad = 0;
  bit          check_en = 1'b0;
  ev_t         exp0[$];
  ev_t         exp1[$];
  logic [1:0]  m_vc [2];
  logic [5:0]  m_dt [2];
  logic [15:0] bq[$];

  logic        o0_fs, o0_fe, o0_ls, o0_le, o0_pv, o0_last, o0_err, o0_tr;
  logic [15:0] o0_fnum, o0_pay;
  logic [5:0]  o0_dt;
  logic [1:0]  o0_vc, o0_be;
  logic        o1_fs, o1_fe, o1_ls, o1_le, o1_pv, o1_last, o1_err, o1_tr;
  logic [15:0] o1_fnum, o1_pay;
  logic [5:0]  o1_dt;
  logic [1:0]  o1_vc, o1_be;

  csirx_packet_handler #(.VC_SELECT(2'd0), .VC_FILTER(1'b0)) dut0 (
    .clk(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid),
    .frame_start(o0_fs), .frame_end(o0_fe), .line_start(o0_ls), .line_end(o0_le),
    .frame_num(o0_fnum), .data_type(o0_dt), .virtual_channel(o0_vc), .payload(o0_pay),
    .payload_valid(o0_pv), .payload_be(o0_be), .payload_last(o0_last),
    .hdr_ecc_err(o0_err), .pkt_truncated(o0_tr));

  csirx_packet_handler #(.VC_SELECT(2'd1), .VC_FILTER(1'b1)) dut1 (
    .clk(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid),
    .frame_start(o1_fs), .frame_end(o1_fe), .line_start(o1_ls), .line_end(o1_le),
    .frame_num(o1_fnum), .data_type(o1_dt), .virtual_channel(o1_vc), .payload(o1_pay),
    .payload_valid(o1_pv), .payload_be(o1_be), .payload_last(o1_last),
    .hdr_ecc_err(o1_err), .pkt_truncated(o1_tr));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL timeout: actual=still running required=finished");
    $fatal(1, "timeout");
  end

  function automatic logic [5:0] ref_ecc(input logic [23:0] d);
    logic [5:0] e;
    e = '0;
    for (int i = 0; i < 24; i++) if (d[i]) e = e ^ ECC_COL[i];
    return e;
  endfunction

  task automatic push_hdr(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                          input int flip);
    logic [7:0]  di;
    logic [31:0] h;
    di = {vc, dt};
    h = {di, wc[7:0], wc[15:8], 2'b00, ref_ecc({wc, di})};
    if (flip >= 0) h[flip] = ~h[flip];
    bq.push_back(h[31:16]);
    bq.push_back(h[15:0]);
  endtask

  task automatic push_words(input int k);
    for (int i = 0; i < k; i++) bq.push_back(16'($urandom));
  endtask

  task automatic push_ev(input int d, input ev_t e);
    if (d == 0) exp0.push_back(e);
    else        exp1.push_back(e);
  endtask

  // Expected events for the burst in bq, first word driven right after edge n0.
  task automatic model(input int d, input bit filt, input logic [1:0] sel, input longint n0);
    int          n;
    int          rem;
    ev_t         e;
    logic [7:0]  di;
    logic [15:0] wc;
    logic [7:0]  ecc;
    n = bq.size();
    e.kind = 5; e.data = 16'h0; e.be = 2'b00; e.last = 1'b0;
    e.dt = m_dt[d]; e.vc = m_vc[d]; e.cyc = n0 + 1 + n;
    if (n < 2) begin
      push_ev(d, e);
      return;
    end
    di  = bq[0][15:8];
    wc  = {bq[1][15:8], bq[0][7:0]};
    ecc = bq[1][7:0];
    if (ecc != {2'b00, ref_ecc({wc, di})}) begin
      e.kind = 4; e.cyc = n0 + 2;
      push_ev(d, e);
      return;
    end
    if (filt && di[7:6] != sel) return;
    m_vc[d] = di[7:6];
    e.vc = m_vc[d];
    if (di[5:0] < 6'h10) begin
      if (di[5:0] < 6'h04) begin
        e.kind = int'(di[5:0]); e.data = wc; e.cyc = n0 + 2;
        push_ev(d, e);
      end
      return;
    end
    m_dt[d] = di[5:0];
    e.dt = m_dt[d];
    rem = int'(wc);
    for (int j = 0; rem > 0; j++) begin
      if (2 + j >= n) begin
        e.kind = 5; e.data = 16'h0; e.be = 2'b00; e.last = 1'b0; e.cyc = n0 + 1 + n;
        push_ev(d, e);
        return;
      end
      e.kind = 6;
      e.data = bq[2 + j];
      e.be   = (rem >= 2) ? 2'b11 : 2'b10;
      rem    = (rem >= 2) ? rem - 2 : 0;
      e.last = (rem == 0);
      e.cyc  = n0 + 3 + j;
      push_ev(d, e);
    end
  endtask

  task automatic send();
    longint n0;
    @(posedge clk); #1;
    n0 = cyc;
    model(0, 1'b0, 2'd0, n0);
    model(1, 1'b1, 2'd1, n0);
    foreach (bq[i]) begin
      word_in = bq[i];
      word_valid = 1'b1;
      @(posedge clk); #1;
    end
    word_valid = 1'b0;
    word_in = 16'($urandom);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    bq.delete();
  endtask

  task automatic check_obs(input int d, input logic [6:0] strb, input logic [15:0] pay,
                           input logic [1:0] be, input logic last, input logic [15:0] fnum,
                           input logic [5:0] dt, input logic [1:0] vc);
    ev_t e;
    ev_t a;
    bit  ok;
    bit  empty;
    for (int k = 0; k < 7; k++) begin
      if (strb[k]) begin
        a.kind = k; a.data = (k == 6) ? pay : fnum; a.be = be; a.last = last;
        a.dt = dt; a.vc = vc; a.cyc = cyc;
        total++;
        empty = (d == 0) ? (exp0.size() == 0) : (exp1.size() == 0);
        if (empty) begin
          bad++;
          $display("FAIL dut%0d unexpected: actual kind=%0d cyc=%0d data=%h, required no event",
                   d, a.kind, a.cyc, a.data);
        end else begin
          if (d == 0) e = exp0.pop_front();
          else        e = exp1.pop_front();
          ok = (a.kind == e.kind) && (a.cyc == e.cyc) && (a.vc == e.vc);
          if (e.kind <= 1) ok = ok && (a.data == e.data);
          if (e.kind == 6)
            ok = ok && (a.data == e.data) && (a.be == e.be) && (a.last == e.last) && (a.dt == e.dt);
          if (!ok) begin
            bad++;
            $display({"FAIL dut%0d event: actual kind=%0d cyc=%0d data=%h be=%b last=%b vc=%0d",
                      " dt=%h, required kind=%0d cyc=%0d data=%h be=%b last=%b vc=%0d dt=%h"},
                     d, a.kind, a.cyc, a.data, a.be, a.last, a.vc, a.dt,
                     e.kind, e.cyc, e.data, e.be, e.last, e.vc, e.dt);
          end
        end
      end
    end
    if (!strb[6] && last) begin
      total++;
      bad++;
      $display("FAIL dut%0d stray_last: actual payload_last=1 cyc=%0d, required 0", d, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check_obs(0, {o0_pv, o0_tr, o0_err, o0_le, o0_ls, o0_fe, o0_fs}, o0_pay, o0_be, o0_last,
                o0_fnum, o0_dt, o0_vc);
      check_obs(1, {o1_pv, o1_tr, o1_err, o1_le, o1_ls, o1_fe, o1_fs}, o1_pay, o1_be, o1_last,
                o1_fnum, o1_dt, o1_vc);
    end
  end

  task automatic chk_zero(input string nm);
    logic [49:0] a0;
    logic [49:0] a1;
    a0 = {o0_fs, o0_fe, o0_ls, o0_le, o0_fnum, o0_dt, o0_vc, o0_pay, o0_pv, o0_be, o0_last,
          o0_err, o0_tr};
    a1 = {o1_fs, o1_fe, o1_ls, o1_le, o1_fnum, o1_dt, o1_vc, o1_pay, o1_pv, o1_be, o1_last,
          o1_err, o1_tr};
    total++;
    if (a0 !== 50'h0) begin
      bad++;
      $display("FAIL %s dut0: actual=%h required=0", nm, a0);
    end
    total++;
    if (a1 !== 50'h0) begin
      bad++;
      $display("FAIL %s dut1: actual=%h required=0", nm, a1);
    end
  endtask

  initial begin
    m_vc[0] = 2'd0; m_vc[1] = 2'd0; m_dt[0] = 6'd0; m_dt[1] = 6'd0;
    #12;
    chk_zero("reset_state");
    @(posedge clk); #1;
    reset = 1'b0;
    check_en = 1'b1;

    bq.push_back(16'h0000); bq.push_back(16'h0000);
    send();
    push_hdr(2'd0, 6'h2B, 16'd6, -1);   push_words(4); send();
    push_hdr(2'd0, 6'h2B, 16'd5, -1);   push_words(4); send();
    push_hdr(2'd0, 6'h2A, 16'd4, 2);    push_words(3); send();
    push_hdr(2'd0, 6'h2C, 16'd100, -1); push_words(10); send();
    push_hdr(2'd0, 6'h01, 16'h1234, -1); send();
    push_hdr(2'd0, 6'h02, 16'h0, -1);   send();
    push_hdr(2'd1, 6'h02, 16'h0, -1);   send();
    push_hdr(2'd1, 6'h00, 16'hBEEF, -1); push_words(1); send();
    bq.push_back(16'h0042); send();

    // Async reset in the middle of a VC1 payload.
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_en = 1'b0;
    push_hdr(2'd1, 6'h2B, 16'd40, -1);
    push_words(6);
    @(posedge clk); #1;
    foreach (bq[i]) begin
      word_in = bq[i];
      word_valid = 1'b1;
      @(posedge clk); #1;
    end
    total++;
    if (o1_pv !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_pv: actual=%b required=1", o1_pv);
    end
    #2;
    reset = 1'b1;
    #1;
    chk_zero("reset_mid_payload");
    bq.delete();
    word_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    m_vc[0] = 2'd0; m_vc[1] = 2'd0; m_dt[0] = 6'd0; m_dt[1] = 6'd0;
    check_en = 1'b1;
    push_hdr(2'd1, 6'h03, 16'h0, -1); send();
    push_hdr(2'd1, 6'h20, 16'd3, -1); push_words(2); send();

    for (int t = 0; t < 250; t++) begin
      logic [1:0]  vc;
      logic [5:0]  dt;
      logic [15:0] wc;
      int          flip;
      int          full;
      int          np;
      vc = 2'($urandom_range(0, 3));
      flip = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : -1;
      if ($urandom_range(0, 3) == 0) begin
        dt = 6'($urandom_range(0, 15));
        wc = 16'($urandom);
      end else begin
        dt = 6'($urandom_range(16, 63));
        wc = 16'($urandom_range(0, 24));
      end
      push_hdr(vc, dt, wc, flip);
      full = (dt >= 6'h10) ? (int'(wc) + 1) / 2 : 0;
      np = full + int'($urandom_range(0, 2));
      if (full > 0 && $urandom_range(0, 5) == 0) np = int'($urandom_range(0, full - 1));
      if ($urandom_range(0, 19) == 0) begin
        void'(bq.pop_back());
        np = 0;
      end
      push_words(np);
      send();
    end

    repeat (6) @(posedge clk);
    total++;
    if (exp0.size() != 0) begin
      bad++;
      $display("FAIL dut0 drained: actual pending=%0d required=0", exp0.size());
    end
    total++;
    if (exp1.size() != 0) begin
      bad++;
      $display("FAIL dut1 drained: actual pending=%0d required=0", exp1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
